// File: rtl/minsec_display.sv
// Purpose: four-digit multiplexed MM:SS display driver with frame-coherent value snapshots and adjust-field blinking.
// Latency: o_an/o_seg are registered and follow the current scan index by exactly one cycle.
// Backpressure: none; the display is a free-running sink with no flow control.
//
// Ports:
//   i_clk              sole clock, all state on its rising edge
//   i_rst              synchronous active-high reset
//   i_minutes[5:0]     binary minutes, snapshotted once per frame
//   i_seconds[5:0]     binary seconds, snapshotted once per frame
//   i_adj              adjust mode, sampled live
//   i_sel              adjust field select (1 = minutes, 0 = seconds), sampled live
//   o_an[3:0]          active-low anode enables, bit 0 = rightmost digit
//   o_seg[6:0]         active-low segments {g,f,e,d,c,b,a}
module minsec_display #(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_minutes,
    input  logic [5:0] i_seconds,
    input  logic       i_adj,
    input  logic       i_sel,
    output logic [3:0] o_an,
    output logic [6:0] o_seg
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    scan_q, scan_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          refresh_wrap;
    logic          frame_latch;
    logic [5:0]    min_c, sec_c;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        refresh_wrap = (refresh_q == REF_MAX);
        refresh_d    = refresh_wrap ? '0 : refresh_q + 1'b1;
        scan_d       = refresh_wrap ? scan_q + 2'd1 : scan_q;

        // Snapshot only as the scan rolls from the last digit back to the
        // first, so every frame is drawn from one coherent value.
        frame_latch  = refresh_wrap && (scan_q == 2'd3);
        min_d        = frame_latch ? i_minutes : min_q;
        sec_d        = frame_latch ? i_seconds : sec_q;

        // Outside adjust mode the blinker parks at count 0 / visible, so the
        // first adjust cycle naturally starts a fresh visible half-period.
        blink_cnt_d  = '0;
        phase_d      = 1'b1;
        if (i_adj) begin
            if (blink_cnt_q == BLK_MAX) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end

        min_c = (min_q > 6'd59) ? 6'd59 : min_q;
        sec_c = (sec_q > 6'd59) ? 6'd59 : sec_q;

        case (scan_q)
            2'd0:    digit = 4'(sec_c % 6'd10);
            2'd1:    digit = 4'(sec_c / 6'd10);
            2'd2:    digit = 4'(min_c % 6'd10);
            default: digit = 4'(min_c / 6'd10);
        endcase

        // scan_q[1] set means a minutes digit; blank it only when it belongs
        // to the field being adjusted and the blink phase is hidden.
        blank = i_adj && !phase_q && (i_sel == scan_q[1]);

        an_d  = ~(4'b0001 << scan_q);
        seg_d = blank ? SEG_BLANK : seg_lut(digit);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            refresh_q   <= '0;
            scan_q      <= 2'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
        end else begin
            refresh_q   <= refresh_d;
            scan_q      <= scan_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign o_an  = an_q;
    assign o_seg = seg_q;

endmodule

// File: doc/minsec_display.md
MINSEC_DISPLAY -- requirements
Module: minsec_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100_000, meaning clock cycles each digit is driven per scan step.
REQ-002 The block SHALL have parameter BLINK_DIV, default 25_000_000, meaning clock cycles per blink half-period.
REQ-003 i_clk  input  1  sole clock; all state SHALL be on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_minutes  input  6  binary minutes value from the minute/second counter.
REQ-006 i_seconds  input  6  binary seconds value from the minute/second counter.
REQ-007 i_adj  input  1  adjust mode active.
REQ-008 i_sel  input  1  adjust field select: 1 = minutes, 0 = seconds.
REQ-009 o_an  output  4  digit anode enables, active-low; bit 0 is the rightmost digit.
REQ-010 o_seg  output  7  segment drives, active-low, bit order {g,f,e,d,c,b,a}.

Function
REQ-011 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; scan index (2 bits) SHALL increment modulo 4 on the cycle the refresh counter is at REFRESH_DIV-1.
REQ-012 Scan index mapping SHALL be: 0 = seconds ones (AN0), 1 = seconds tens (AN1), 2 = minutes ones (AN2), 3 = minutes tens (AN3).
REQ-013 Displayed values SHALL be snapshots: i_minutes and i_seconds SHALL be latched only on the cycle the scan index advances from 3 to 0, so that one full frame shows a coherent value.
REQ-014 Latched values above 59 SHALL be clamped to 59 before conversion.
REQ-015 Conversion SHALL be tens = value/10 and ones = value%10, giving digit range 0..5 for tens and 0..9 for ones.
REQ-016 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-017 o_an and o_seg SHALL be registered and SHALL reflect the current scan index with exactly 1 cycle latency.
REQ-018 Exactly one o_an bit SHALL be low in every non-reset cycle after the first post-reset cycle.
REQ-019 Blink counter SHALL count 0..BLINK_DIV-1 and toggle the blink phase at wrap; phase 1 = visible, 0 = hidden.
REQ-020 While i_adj=0, the blink counter SHALL be held at 0 and the phase forced to visible.
REQ-021 On a rising edge of i_adj, blinking SHALL start from counter 0 with the phase visible.
REQ-022 While i_adj=1 and the phase is hidden, the digits of the selected field SHALL drive o_seg=blank with their anode still asserted; the other field SHALL display normally.
REQ-023 A change of i_sel mid-blink SHALL take effect on the next output register update without resetting the blink counter.
REQ-024 i_adj and i_sel SHALL be sampled live (not snapshot); only the numeric values are frame-latched.

Reset
REQ-025 When i_rst=1 at a clock edge, the following SHALL be set: refresh counter 0, scan index 0, latched minutes and seconds 0, blink counter 0, blink phase visible, o_an=1111, o_seg=1111111.
REQ-026 Reset asserted mid-frame or mid-blink SHALL take priority over all other updates.
REQ-027 After reset release, the display SHALL show 00:00 until the first 3-to-0 latch event.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-028 Reset, then min=12 and sec=34 held -> first frame shows 0; after the first 3-to-0 wrap, AN0..AN3 carry o_seg 0011001, 0110000, 0100100, 1111001, each for 4 cycles, in the order 1110, 1101, 1011, 0111.
REQ-029 Change sec from 34 to 35 mid-frame (scan index 1) -> the digits keep showing 34 until the next index-0 step, then show 35; no mixed frame.
REQ-030 sec=63 latched -> displayed as 59 (AN1 0010010, AN0 0010000).
REQ-031 i_adj=1, i_sel=0, min=5, sec=7 -> AN0/AN1 segments alternate between digits and 1111111 every 16 cycles, starting visible; AN2/AN3 are always 0010010/1000000.
REQ-032 Toggle i_sel to 1 during a hidden phase -> the minutes digits blank and the seconds digits reappear on the next output update; the blink period is unchanged.
REQ-033 Assert i_rst for 1 cycle at scan index 2 -> next cycle o_an=1111, o_seg=1111111; the scan restarts at AN0 and shows 00:00.
